// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and widths for the CPU run controller: FSM state encoding and
// the instruction, pc, result and program-length widths.
package cpu_run_ctrl_pkg;

    localparam int INSN_W   = 16;
    localparam int PC_W     = 10;
    localparam int RESULT_W = 8;
    // One bit wider than pc so a completely full memory can be counted.
    localparam int NUM_W    = PC_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CPURST = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Program-word load stream between a loader (master) and the run controller (slave).
interface cpu_run_ctrl_if;
    import cpu_run_ctrl_pkg::*;

    // A word transfers on a rising clk edge where load_valid and load_ready are both 1;
    // load_ready never depends on load_valid, and load_last marks the final word of a program.
    logic              load_valid;
    logic [INSN_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );

endinterface

// File: rtl/cpu_run_ctrl_insn_ram.sv
// Program store for the run controller: synchronous write, asynchronous read,
// no reset (contents are undefined until loaded).
module insn_ram
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PC_W-1:0]   i_waddr,
    input  logic [INSN_W-1:0] i_wdata,
    input  logic [PC_W-1:0]   i_raddr,
    output logic [INSN_W-1:0] o_rdata
);

    logic [INSN_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Loads a program into instruction RAM, then holds an attached CPU in reset, runs it,
// and captures its result or a timeout. Define SINGLE_STEP_EN to add a step input.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                clk,
    input  logic                rst,
    cpu_run_ctrl_if.slave       load,
    input  logic                start,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                cpu_rst,
    output logic [INSN_W-1:0]   insn,
    output logic [PC_W-1:0]     pc,
    input  logic                reg0_wr,
    input  logic [RESULT_W-1:0] reg0,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [RESULT_W-1:0] result,
    output logic [NUM_W-1:0]    num_insn,
    output state_t              dbg_state
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NUM_W-1:0] DEPTH_N   = NUM_W'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CYCLES);

    state_t              r_state, w_state_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt;
    logic [NUM_W-1:0]    r_num, w_num_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                r_done, w_done_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic [RESULT_W-1:0] r_result, w_result_nxt;
    logic                w_can_load, w_accept, w_adv;
    logic                w_we;
    logic [PC_W-1:0]     w_waddr;

`ifdef SINGLE_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    assign w_can_load = ((r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DONE))
                        && (r_num < DEPTH_N);
    assign w_accept   = load.load_valid && w_can_load;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // A word accepted in IDLE/DONE starts a new program; a start in that same cycle is dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_num_nxt     = r_num;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = r_done;
        w_timeout_nxt = r_timeout;
        w_result_nxt  = r_result;
        w_we          = 1'b0;
        w_waddr       = r_num[PC_W-1:0];
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_we          = 1'b1;
                    w_waddr       = '0;
                    w_num_nxt     = NUM_W'(1);
                    w_done_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = (load.load_last || (DEPTH_N == NUM_W'(1))) ? ST_IDLE : ST_LOAD;
                end else if (start && (r_num != '0)) begin
                    w_pc_nxt      = '0;
                    w_cnt_nxt     = '0;
                    w_done_nxt    = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_CPURST;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_we      = 1'b1;
                    w_num_nxt = r_num + NUM_W'(1);
                    if (load.load_last || (w_num_nxt == DEPTH_N)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CPURST: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (reg0_wr) begin
                    w_result_nxt  = reg0;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else if (w_adv) begin
                    w_cnt_nxt = w_cnt_inc;
                    if ({1'b0, r_pc} < (r_num - NUM_W'(1))) begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                    if (w_cnt_inc == TIMEOUT_N) begin
                        w_done_nxt    = 1'b1;
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_num     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_num     <= w_num_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_result  <= w_result_nxt;
        end
    end

    insn_ram #(
        .DEPTH (DEPTH)
    ) u_insn_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (load.load_data),
        .i_raddr (r_pc),
        .o_rdata (insn)
    );

    assign load.load_ready = w_can_load;
    assign cpu_rst         = (r_state != ST_RUN);
    assign busy            = (r_state == ST_LOAD) || (r_state == ST_CPURST) || (r_state == ST_RUN);
    assign pc              = r_pc;
    assign done            = r_done;
    assign timeout         = r_timeout;
    assign result          = r_result;
    assign num_insn        = r_num;
    assign dbg_state       = r_state;

endmodule
